draw_frame_sequencer: RTL and testbench
=======================================

Name: draw_frame_sequencer

Overview:
- Upstream controller for the background, gold and stone draw FSMs.
- On each frame tick it draws the full background first. It then draws every present gold item, then every present stone item.
- It drives the object index used by the position/sprite lookup and the source select for the shared VGA write mux.
- It reports frame completion to the game-logic layer.

Parameters:
- NUM_GOLD, 4, number of gold slots (1..8).
- NUM_STONE, 3, number of stone slots (1..8).
- IDX_W, 3, width of object_index; must satisfy 2^IDX_W >= max(NUM_GOLD, NUM_STONE).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- frame_start  in  1  one-cycle frame tick from the game timer.
- gold_present  in  NUM_GOLD  bit i = gold slot i still on field.
- stone_present  in  NUM_STONE  bit i = stone slot i still on field.
- draw_background_done  in  1  done pulse from the background draw FSM.
- draw_gold_done  in  1  done pulse from the gold draw FSM.
- draw_stone_done  in  1  done pulse from the stone draw FSM.
- enable_draw_background  out  1  level; held high until background done.
- enable_draw_gold  out  1  one-cycle start pulse.
- enable_draw_stone  out  1  one-cycle start pulse.
- object_index  out  IDX_W  slot currently being drawn.
- vga_src_sel  out  2  0 = none, 1 = background, 2 = gold, 3 = stone.
- frame_busy  out  1  high from frame acceptance until FRAME_DONE inclusive.
- frame_done  out  1  one-cycle pulse when the frame is complete.
- frame_overrun  out  1  one-cycle pulse when frame_start arrives while busy.

Behaviour:
- Reset (sync, active-high, overrides everything):
  - state = IDLE.
  - All outputs 0; object_index = 0; mask snapshots cleared.
  - Reset mid-frame aborts the frame immediately; downstream FSMs are reset by the same system reset.
- States: IDLE, BG_WAIT, GOLD_SCAN, GOLD_START, GOLD_WAIT, STONE_SCAN, STONE_START, STONE_WAIT, FRAME_DONE.
- IDLE, on frame_start:
  - Snapshot gold_present and stone_present into internal masks.
  - object_index <= 0.
  - Go to BG_WAIT.
  - Present-mask changes during a frame have no effect.
- BG_WAIT:
  - enable_draw_background = 1; vga_src_sel = 1.
  - Enable is a level because the background FSM re-samples its enable on every pixel.
  - On draw_background_done: go to GOLD_SCAN; object_index <= 0.
- GOLD_SCAN, one cycle per slot:
  - If object_index == NUM_GOLD: go to STONE_SCAN; object_index <= 0.
  - Else if mask bit set: go to GOLD_START.
  - Else object_index++ and stay in GOLD_SCAN.
- GOLD_START:
  - enable_draw_gold = 1 for exactly one cycle; vga_src_sel = 2.
  - Go to GOLD_WAIT.
  - A single cycle is required because the gold FSM restarts if its enable is still high when it returns to its load state.
- GOLD_WAIT:
  - vga_src_sel = 2; object_index held stable.
  - On draw_gold_done: object_index++; go to GOLD_SCAN.
- STONE_SCAN / STONE_START / STONE_WAIT: identical to the gold states, using NUM_STONE, enable_draw_stone, draw_stone_done and vga_src_sel = 3. Exit from STONE_SCAN goes to FRAME_DONE.
- FRAME_DONE:
  - frame_done = 1 for one cycle; vga_src_sel = 0.
  - Go to IDLE.
  - frame_start in this cycle is ignored and flagged as overrun.
- frame_busy = (state != IDLE).
- frame_overrun pulses on any frame_start seen while state != IDLE; that request is dropped and not queued.
- Done pulses received in any state other than the matching *_WAIT are ignored.
- Empty masks: a frame with no gold and no stone costs background time + (NUM_GOLD+1) + (NUM_STONE+1) + 1 cycles beyond it.
- object_index arithmetic is unsigned IDX_W+1 internally so that the compare against NUM_GOLD = 2^IDX_W does not wrap. The output is the low IDX_W bits.

Decomposition:
- Shared package (draw_pkg):
  - State encoding localparams.
  - VGA_SRC_NONE/BG/GOLD/STONE constants (0..3).
- Sub-module obj_slot_scanner, instantiated once per object class. It handles:
  - mask snapshot;
  - index counter;
  - "next present slot / end reached" outputs.
- The top FSM only sequences the phases.

Test Plan:
1. Reset high for 2 cycles, then low → all outputs 0, state IDLE, frame_busy = 0.
2. frame_start with gold_present = 4'b0101, stone_present = 3'b010; done pulses returned 5 cycles after each enable → sequence is:
   - BG (enable level until done);
   - gold pulses with object_index 0, then 2;
   - stone pulse with index 1;
   - then frame_done once. vga_src_sel follows 1, 2, 2, 3, 0.
3. Both masks 0 → background only; frame_done exactly (1 + 5 + 4 + 1) cycles after background done.
4. frame_start asserted again while in GOLD_WAIT → frame_overrun pulses one cycle; frame completes normally; no second frame begins.
5. gold_present toggled from 4'b1111 to 4'b0000 mid-frame → all 4 gold draws still issued (snapshot honoured).
6. Reset asserted during STONE_WAIT → next cycle all outputs 0 and state IDLE; a spurious draw_stone_done afterward is ignored.

Source files
------------

// File: rtl/draw_pkg.sv
// Shared types and constants for the frame draw sequencer.
package draw_pkg;

    // Sequencer phases
    typedef enum logic [3:0] {
        ST_IDLE,
        ST_BG_WAIT,
        ST_GOLD_SCAN,
        ST_GOLD_START,
        ST_GOLD_WAIT,
        ST_STONE_SCAN,
        ST_STONE_START,
        ST_STONE_WAIT,
        ST_FRAME_DONE
    } seq_state_e;

    // Source select codes for the shared VGA write mux
    localparam logic [1:0] VGA_SRC_NONE  = 2'd0;
    localparam logic [1:0] VGA_SRC_BG    = 2'd1;
    localparam logic [1:0] VGA_SRC_GOLD  = 2'd2;
    localparam logic [1:0] VGA_SRC_STONE = 2'd3;

endpackage

// File: rtl/obj_slot_scanner.sv
// Per-class slot walker: holds the frame's present-mask snapshot and the
// slot index, and reports whether the current slot is occupied or the
// walk has run past the last slot.
module obj_slot_scanner #(
    parameter int NUM   = 4,
    parameter int IDX_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,     // frame accepted: snapshot mask, index to 0
    input  logic [NUM-1:0]   present_i,
    input  logic             clr_i,      // start of this class's phase
    input  logic             inc_i,      // advance to next slot
    output logic [IDX_W-1:0] idx_o,
    output logic             end_o,      // index == NUM, walk finished
    output logic             hit_o       // current slot present in snapshot
);

    // One extra bit so NUM == 2**IDX_W is reachable without wrapping.
    logic [IDX_W:0]   idx_q, idx_d;
    logic [NUM-1:0]   mask_q, mask_d;

    // Next-state for snapshot and index
    always_comb begin
        mask_d = mask_q;
        idx_d  = idx_q;
        if (load_i) begin
            mask_d = present_i;
        end
        if (load_i || clr_i) begin
            idx_d = '0;
        end else if (inc_i) begin
            idx_d = idx_q + 1'b1;
        end
    end

    // Snapshot and index registers
    always_ff @(posedge clk) begin
        if (reset) begin
            mask_q <= '0;
            idx_q  <= '0;
        end else begin
            mask_q <= mask_d;
            idx_q  <= idx_d;
        end
    end

    // Slot lookup; out-of-range indices read as absent
    always_comb begin
        hit_o = 1'b0;
        for (int i = 0; i < NUM; i++) begin
            if (idx_q == (IDX_W+1)'(i)) hit_o = mask_q[i];
        end
    end

    assign end_o = (idx_q == (IDX_W+1)'(NUM));
    assign idx_o = idx_q[IDX_W-1:0];

endmodule

// File: rtl/draw_frame_sequencer.sv
// Frame sequencer: background, then each present gold slot, then each
// present stone slot, then a frame-done pulse.
module draw_frame_sequencer
    import draw_pkg::*;
#(
    parameter int NUM_GOLD  = 4,
    parameter int NUM_STONE = 3,
    parameter int IDX_W     = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 frame_start,
    input  logic [NUM_GOLD-1:0]  gold_present,
    input  logic [NUM_STONE-1:0] stone_present,
    input  logic                 draw_background_done,
    input  logic                 draw_gold_done,
    input  logic                 draw_stone_done,
    output logic                 enable_draw_background,
    output logic                 enable_draw_gold,
    output logic                 enable_draw_stone,
    output logic [IDX_W-1:0]     object_index,
    output logic [1:0]           vga_src_sel,
    output logic                 frame_busy,
    output logic                 frame_done,
    output logic                 frame_overrun
);

    seq_state_e state_q, state_d;

    logic             load;
    logic             g_clr, g_inc, g_end, g_hit;
    logic             s_clr, s_inc, s_end, s_hit;
    logic [IDX_W-1:0] g_idx, s_idx;

    obj_slot_scanner #(.NUM(NUM_GOLD), .IDX_W(IDX_W)) u_gold (
        .clk       (clk),
        .reset     (reset),
        .load_i    (load),
        .present_i (gold_present),
        .clr_i     (g_clr),
        .inc_i     (g_inc),
        .idx_o     (g_idx),
        .end_o     (g_end),
        .hit_o     (g_hit)
    );

    obj_slot_scanner #(.NUM(NUM_STONE), .IDX_W(IDX_W)) u_stone (
        .clk       (clk),
        .reset     (reset),
        .load_i    (load),
        .present_i (stone_present),
        .clr_i     (s_clr),
        .inc_i     (s_inc),
        .idx_o     (s_idx),
        .end_o     (s_end),
        .hit_o     (s_hit)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Phase sequencing, scanner control and outputs
    always_comb begin
        state_d                = state_q;
        load                   = 1'b0;
        g_clr                  = 1'b0;
        g_inc                  = 1'b0;
        s_clr                  = 1'b0;
        s_inc                  = 1'b0;
        enable_draw_background = 1'b0;
        enable_draw_gold       = 1'b0;
        enable_draw_stone      = 1'b0;
        vga_src_sel            = VGA_SRC_NONE;
        frame_done             = 1'b0;
        object_index           = '0;

        case (state_q)
            ST_IDLE: begin
                if (frame_start) begin
                    load    = 1'b1;
                    state_d = ST_BG_WAIT;
                end
            end
            ST_BG_WAIT: begin
                // Level enable: the background FSM re-samples it per pixel.
                enable_draw_background = 1'b1;
                vga_src_sel            = VGA_SRC_BG;
                if (draw_background_done) begin
                    g_clr   = 1'b1;
                    state_d = ST_GOLD_SCAN;
                end
            end
            ST_GOLD_SCAN: begin
                object_index = g_idx;
                if (g_end) begin
                    s_clr   = 1'b1;
                    state_d = ST_STONE_SCAN;
                end else if (g_hit) begin
                    state_d = ST_GOLD_START;
                end else begin
                    g_inc = 1'b1;
                end
            end
            ST_GOLD_START: begin
                // Single-cycle start so the gold FSM does not re-trigger.
                object_index     = g_idx;
                enable_draw_gold = 1'b1;
                vga_src_sel      = VGA_SRC_GOLD;
                state_d          = ST_GOLD_WAIT;
            end
            ST_GOLD_WAIT: begin
                object_index = g_idx;
                vga_src_sel  = VGA_SRC_GOLD;
                if (draw_gold_done) begin
                    g_inc   = 1'b1;
                    state_d = ST_GOLD_SCAN;
                end
            end
            ST_STONE_SCAN: begin
                object_index = s_idx;
                if (s_end) begin
                    state_d = ST_FRAME_DONE;
                end else if (s_hit) begin
                    state_d = ST_STONE_START;
                end else begin
                    s_inc = 1'b1;
                end
            end
            ST_STONE_START: begin
                object_index      = s_idx;
                enable_draw_stone = 1'b1;
                vga_src_sel       = VGA_SRC_STONE;
                state_d           = ST_STONE_WAIT;
            end
            ST_STONE_WAIT: begin
                object_index = s_idx;
                vga_src_sel  = VGA_SRC_STONE;
                if (draw_stone_done) begin
                    s_inc   = 1'b1;
                    state_d = ST_STONE_SCAN;
                end
            end
            ST_FRAME_DONE: begin
                object_index = s_idx;
                frame_done   = 1'b1;
                state_d      = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Reset wins over everything, including the combinational outputs.
        if (reset) begin
            enable_draw_background = 1'b0;
            enable_draw_gold       = 1'b0;
            enable_draw_stone      = 1'b0;
            vga_src_sel            = VGA_SRC_NONE;
            frame_done             = 1'b0;
            object_index           = '0;
        end
    end

    assign frame_busy    = (state_q != ST_IDLE) && !reset;
    // A frame tick while busy is dropped, never queued.
    assign frame_overrun = frame_start && (state_q != ST_IDLE) && !reset;

endmodule

// File: tb/tb_draw_frame_sequencer.sv
// Directed bench for draw_frame_sequencer with a 5-cycle downstream responder.
module tb_draw_frame_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       frame_start;
    logic [3:0] gold_present;
    logic [2:0] stone_present;
    logic       draw_background_done;
    logic       draw_gold_done;
    logic       draw_stone_done;
    logic       enable_draw_background;
    logic       enable_draw_gold;
    logic       enable_draw_stone;
    logic [2:0] object_index;
    logic [1:0] vga_src_sel;
    logic       frame_busy;
    logic       frame_done;
    logic       frame_overrun;

    int total = 0;
    int bad   = 0;
    bit resp_en = 1'b0;
    logic [7:0] log_q[$];
    logic [7:0] exp_q[$];
    logic       bg_prev = 1'b0;

    always #5 clk = ~clk;

    draw_frame_sequencer #(.NUM_GOLD(4), .NUM_STONE(3), .IDX_W(3)) dut (
        .clk                    (clk),
        .reset                  (reset),
        .frame_start            (frame_start),
        .gold_present           (gold_present),
        .stone_present          (stone_present),
        .draw_background_done   (draw_background_done),
        .draw_gold_done         (draw_gold_done),
        .draw_stone_done        (draw_stone_done),
        .enable_draw_background (enable_draw_background),
        .enable_draw_gold       (enable_draw_gold),
        .enable_draw_stone      (enable_draw_stone),
        .object_index           (object_index),
        .vga_src_sel            (vga_src_sel),
        .frame_busy             (frame_busy),
        .frame_done             (frame_done),
        .frame_overrun          (frame_overrun)
    );

    // event code: {vga_src_sel, kind (1 bg, 2 gold, 3 stone, 4 done), index}
    function automatic logic [7:0] enc(input logic [1:0] v, input logic [2:0] k, input logic [2:0] i);
        return {v, k, i};
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_log(input string tag);
        chk({tag, "_len"}, log_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < log_q.size()) chk($sformatf("%s_ev%0d", tag, i), log_q[i], exp_q[i]);
        end
    endtask

    task automatic wait_done(input int max, output int n);
        n = 0;
        while (!frame_done && n < max) begin
            tick();
            n++;
        end
    endtask

    // Event monitor: records start strobes and frame completion
    always begin
        @(posedge clk);
        #1;
        if (enable_draw_background && !bg_prev) log_q.push_back(enc(vga_src_sel, 3'd1, object_index));
        if (enable_draw_gold)  log_q.push_back(enc(vga_src_sel, 3'd2, object_index));
        if (enable_draw_stone) log_q.push_back(enc(vga_src_sel, 3'd3, object_index));
        if (frame_done)        log_q.push_back(enc(vga_src_sel, 3'd4, 3'd0));
        bg_prev = enable_draw_background;
    end

    // Downstream responders: done pulse five cycles after each enable
    initial begin
        draw_background_done = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (resp_en && enable_draw_background) begin
                repeat (4) begin @(posedge clk); #1; end
                draw_background_done = 1'b1;
                @(posedge clk); #1;
                draw_background_done = 1'b0;
            end
        end
    end

    initial begin
        draw_gold_done = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (resp_en && enable_draw_gold) begin
                repeat (4) begin @(posedge clk); #1; end
                draw_gold_done = 1'b1;
                @(posedge clk); #1;
                draw_gold_done = 1'b0;
            end
        end
    end

    initial begin
        draw_stone_done = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (resp_en && enable_draw_stone) begin
                repeat (4) begin @(posedge clk); #1; end
                draw_stone_done = 1'b1;
                @(posedge clk); #1;
                draw_stone_done = 1'b0;
            end
        end
    end

    initial begin
        int n;
        reset = 1'b1; frame_start = 1'b0;
        gold_present = 4'b0000; stone_present = 3'b000;

        // reset state
        tick(); tick();
        reset = 1'b0;
        tick();
        chk("rst_en_bg",   enable_draw_background, 1'b0);
        chk("rst_en_gold", enable_draw_gold, 1'b0);
        chk("rst_en_stone",enable_draw_stone, 1'b0);
        chk("rst_idx",     object_index, 3'd0);
        chk("rst_vga",     vga_src_sel, 2'd0);
        chk("rst_busy",    frame_busy, 1'b0);
        chk("rst_done",    frame_done, 1'b0);
        chk("rst_ovr",     frame_overrun, 1'b0);

        // mixed masks: gold 0 and 2, stone 1
        resp_en = 1'b1;
        log_q.delete();
        gold_present = 4'b0101; stone_present = 3'b010;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        chk("t2_busy",  frame_busy, 1'b1);
        chk("t2_en_bg", enable_draw_background, 1'b1);
        chk("t2_vga",   vga_src_sel, 2'd1);
        wait_done(300, n);
        chk("t2_done_seen", frame_done, 1'b1);
        chk("t2_busy_at_done", frame_busy, 1'b1);
        tick();
        chk("t2_done_one_cycle", frame_done, 1'b0);
        chk("t2_busy_after", frame_busy, 1'b0);
        exp_q = '{enc(2'd1,3'd1,3'd0), enc(2'd2,3'd2,3'd0), enc(2'd2,3'd2,3'd2),
                  enc(2'd3,3'd3,3'd1), enc(2'd0,3'd4,3'd0)};
        check_log("t2");

        // empty masks: scan-only timing after background done
        resp_en = 1'b0;
        repeat (2) tick();
        log_q.delete();
        gold_present = 4'b0000; stone_present = 3'b000;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        tick(); tick();
        draw_background_done = 1'b1;
        tick();
        draw_background_done = 1'b0;
        n = 1;
        while (!frame_done && n < 40) begin tick(); n++; end
        chk("t3_cycles_after_bg_done", n, 10);
        chk("t3_done_vga", vga_src_sel, 2'd0);
        tick();
        chk("t3_done_pulse_end", frame_done, 1'b0);
        exp_q = '{enc(2'd1,3'd1,3'd0), enc(2'd0,3'd4,3'd0)};
        check_log("t3");

        // overrun while in GOLD_WAIT
        resp_en = 1'b1;
        repeat (2) tick();
        log_q.delete();
        gold_present = 4'b0001; stone_present = 3'b000;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        n = 0;
        while (!enable_draw_gold && n < 40) begin tick(); n++; end
        chk("t4_gold_start_seen", enable_draw_gold, 1'b1);
        tick();
        frame_start = 1'b1;
        #1;
        chk("t4_overrun", frame_overrun, 1'b1);
        tick();
        frame_start = 1'b0;
        #1;
        chk("t4_overrun_one_cycle", frame_overrun, 1'b0);
        wait_done(100, n);
        chk("t4_done_seen", frame_done, 1'b1);
        repeat (12) tick();
        chk("t4_no_second_frame", frame_busy, 1'b0);
        exp_q = '{enc(2'd1,3'd1,3'd0), enc(2'd2,3'd2,3'd0), enc(2'd0,3'd4,3'd0)};
        check_log("t4");

        // mask cleared mid-frame: snapshot still drives all four gold draws
        log_q.delete();
        gold_present = 4'b1111; stone_present = 3'b000;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        gold_present = 4'b0000;
        wait_done(300, n);
        chk("t5_done_seen", frame_done, 1'b1);
        tick();
        exp_q = '{enc(2'd1,3'd1,3'd0), enc(2'd2,3'd2,3'd0), enc(2'd2,3'd2,3'd1),
                  enc(2'd2,3'd2,3'd2), enc(2'd2,3'd2,3'd3), enc(2'd0,3'd4,3'd0)};
        check_log("t5");

        // reset during STONE_WAIT, then a stray stone done
        resp_en = 1'b0;
        repeat (8) tick();
        gold_present = 4'b0000; stone_present = 3'b001;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        draw_background_done = 1'b1;
        tick();
        draw_background_done = 1'b0;
        n = 0;
        while (!enable_draw_stone && n < 30) begin tick(); n++; end
        chk("t6_stone_start_seen", enable_draw_stone, 1'b1);
        chk("t6_stone_idx", object_index, 3'd0);
        tick();
        chk("t6_wait_vga", vga_src_sel, 2'd3);
        reset = 1'b1;
        tick();
        chk("t6_rst_busy",  frame_busy, 1'b0);
        chk("t6_rst_vga",   vga_src_sel, 2'd0);
        chk("t6_rst_idx",   object_index, 3'd0);
        chk("t6_rst_en_bg", enable_draw_background, 1'b0);
        reset = 1'b0;
        draw_stone_done = 1'b1;
        tick();
        draw_stone_done = 1'b0;
        tick();
        chk("t6_spurious_busy",  frame_busy, 1'b0);
        chk("t6_spurious_stone", enable_draw_stone, 1'b0);
        chk("t6_spurious_done",  frame_done, 1'b0);
        chk("t6_spurious_vga",   vga_src_sel, 2'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
